// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
//   Shared definitions for the parametrised serial pattern detector.
//   - PAT_W_MAX  : widest pattern the detector supports
//   - det_mode_t : overlapping / non-overlapping detection mode
//   - match_fn   : compares the accepted history plus the current bit against
//                  the pattern. Only the low pat_w bits take part.
// -----------------------------------------------------------------------------
package seq_det_pkg;

  localparam int PAT_W_MAX = 16;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } det_mode_t;

  // hist and pattern are zero-extended to the maximum width by the caller.
  // The current bit x becomes bit 0 of the compared word, so the MSB of the
  // pattern lines up with the oldest history bit.
  function automatic logic match_fn(
    input logic [PAT_W_MAX-2:0] hist,
    input logic                 x,
    input logic [PAT_W_MAX-1:0] pattern,
    input int unsigned          pat_w
  );
    logic [PAT_W_MAX-1:0] word;
    logic                 eq;
    word = {hist, x};
    eq   = 1'b1;
    for (int i = 0; i < PAT_W_MAX; i++) begin
      if ((i < pat_w) && (word[i] != pattern[i])) begin
        eq = 1'b0;
      end else begin
        eq = eq;
      end
    end
    return eq;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with a sticky saturation flag.
//   Ports:
//     clk    in  1  clock, rising edge
//     reset  in  1  synchronous, active-high reset
//     inc    in  1  count one event this cycle
//     cnt    out W  current count, stops at all-ones
//     sat    out 1  set in the same edge the count reaches all-ones; cleared
//                   only by reset
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_n_s;
  logic         sat_r;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_n_s = cnt_r;
    if (inc && (cnt_r != ALL_ONES)) begin
      cnt_n_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_n_s = cnt_r;
    end
  end

  // Count and sticky saturation flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {W{1'b0}};
      sat_r <= 1'b0;
    end else begin
      cnt_r <= cnt_n_s;
      sat_r <= sat_r | (cnt_n_s == ALL_ONES);
    end
  end

  assign cnt = cnt_r;
  assign sat = sat_r;

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Parametrised serial pattern detector on a 1-bit stream, with run-time
//   overlapping / non-overlapping selection and an input qualifier.
//   Optional feature macro: SEQ_DET_CNT_EN adds a saturating match counter;
//   without it match_cnt and cnt_sat are tied to zero.
//   Parameters: PAT_W (2..16), PATTERN (MSB = oldest bit), CNT_W.
//   Ports:
//     clk        in  1      clock, rising edge
//     reset      in  1      synchronous, active-high reset
//     x          in  1      serial data bit, used only when en=1
//     en         in  1      x is a valid bit this cycle
//     overlap    in  1      1 = overlapping, 0 = history cleared on a match
//     y_mealy    out 1      combinational match strobe on the last pattern bit
//     y_moore    out 1      registered match strobe, one cycle after y_mealy
//     match_cnt  out CNT_W  saturating match count
//     cnt_sat    out 1      sticky: match_cnt has reached all-ones
// -----------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  output logic             y_mealy,
  output logic             y_moore,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist_r;
  logic [PAT_W-2:0]  hist_n_s;
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_n_s;
  logic [PAT_W-1:0]  shift_s;
  logic              full_s;
  logic              hit_s;
  logic              y_moore_r;
  det_mode_t         mode_s;

  // Match decode. A hit needs a full history so that no match can be built
  // from bits that pre-date reset or a non-overlap clear.
  always_comb begin
    mode_s  = det_mode_t'(overlap);
    full_s  = (fill_r == FILL_FULL);
    shift_s = {hist_r, x};
    hit_s   = en & full_s &
              match_fn((PAT_W_MAX-1)'(hist_r), x, PAT_W_MAX'(PATTERN), PAT_W);
  end

  // History / fill next state. The shifted word drops its oldest bit, which
  // also covers PAT_W=2 where the history is a single bit.
  always_comb begin
    hist_n_s = hist_r;
    fill_n_s = fill_r;
    if (en) begin
      if (hit_s && (mode_s == MODE_NONOVL)) begin
        hist_n_s = {(PAT_W-1){1'b0}};
        fill_n_s = {FILL_W{1'b0}};
      end else begin
        hist_n_s = shift_s[PAT_W-2:0];
        fill_n_s = full_s ? fill_r : (fill_r + {{(FILL_W-1){1'b0}}, 1'b1});
      end
    end else begin
      hist_n_s = hist_r;
      fill_n_s = fill_r;
    end
  end

  // History, fill and registered match strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_r    <= {(PAT_W-1){1'b0}};
      fill_r    <= {FILL_W{1'b0}};
      y_moore_r <= 1'b0;
    end else begin
      hist_r    <= hist_n_s;
      fill_r    <= fill_n_s;
      y_moore_r <= hit_s;
    end
  end

  assign y_mealy = hit_s & ~reset;
  assign y_moore = y_moore_r;

`ifdef SEQ_DET_CNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_s),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );
`else
  assign match_cnt = {CNT_W{1'b0}};
  assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//   Directed bench for seq_detector_param. Three instances share one stimulus
//   stream: "101" with 8-bit counter, "101" with 2-bit counter, and "1111".
//   Counter expectations depend on whether SEQ_DET_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       x;
  logic       en;
  logic       overlap;

  logic       y_mealy3,  y_moore3;
  logic [7:0] match_cnt3;
  logic       cnt_sat3;
  logic       y_mealy3c, y_moore3c;
  logic [1:0] match_cnt3c;
  logic       cnt_sat3c;
  logic       y_mealy4,  y_moore4;
  logic [7:0] match_cnt4;
  logic       cnt_sat4;

  int n_cmp;
  int n_err;

  seq_detector_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap),
    .y_mealy(y_mealy3), .y_moore(y_moore3),
    .match_cnt(match_cnt3), .cnt_sat(cnt_sat3)
  );

  seq_detector_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) dut3c (
    .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap),
    .y_mealy(y_mealy3c), .y_moore(y_moore3c),
    .match_cnt(match_cnt3c), .cnt_sat(cnt_sat3c)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap),
    .y_mealy(y_mealy4), .y_moore(y_moore4),
    .match_cnt(match_cnt4), .cnt_sat(cnt_sat4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle of stimulus: mealy checked mid-cycle, moore just after the edge.
  task automatic bit_in(input logic rst_v, input logic x_v, input logic en_v,
                        input logic exp3, input logic exp4);
    @(negedge clk);
    reset = rst_v;
    x     = x_v;
    en    = en_v;
    #1;
    check_eq("mealy3",  {31'd0, y_mealy3},  {31'd0, exp3});
    check_eq("mealy3c", {31'd0, y_mealy3c}, {31'd0, exp3});
    check_eq("mealy4",  {31'd0, y_mealy4},  {31'd0, exp4});
    @(posedge clk);
    #1;
    check_eq("moore3",  {31'd0, y_moore3},  {31'd0, exp3});
    check_eq("moore4",  {31'd0, y_moore4},  {31'd0, exp4});
  endtask

  task automatic do_reset();
    bit_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_cnt(input string tag, input int exp3, input int exp3c, input logic exp_sat3c);
    check_eq({tag, "_cnt3"},  {24'd0, match_cnt3},  CNT_ON ? 32'(exp3)  : 32'd0);
    check_eq({tag, "_cnt3c"}, {30'd0, match_cnt3c}, CNT_ON ? 32'(exp3c) : 32'd0);
    check_eq({tag, "_sat3c"}, {31'd0, cnt_sat3c},   {31'd0, CNT_ON & exp_sat3c});
    check_eq({tag, "_sat3"},  {31'd0, cnt_sat3},    32'd0);
  endtask

  initial begin
    logic [4:0] s1;
    logic [4:0] e1;
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    x       = 1'b0;
    en      = 1'b0;
    overlap = 1'b1;

    do_reset();
    do_reset();
    check_cnt("reset", 0, 0, 1'b0);

    // T1: 1,0,1,0,1 overlapping -> hits on bits 3 and 5
    overlap = 1'b1;
    s1 = 5'b10101;
    e1 = 5'b00101;
    for (int i = 4; i >= 0; i--) bit_in(1'b0, s1[i], 1'b1, e1[i], 1'b0);
    check_cnt("t1", 2, 2, 1'b0);
    do_reset();
    check_cnt("t1rst", 0, 0, 1'b0);

    // T2: same stream non-overlapping -> only bit 3
    overlap = 1'b0;
    e1 = 5'b00100;
    for (int i = 4; i >= 0; i--) bit_in(1'b0, s1[i], 1'b1, e1[i], 1'b0);
    check_cnt("t2", 1, 1, 1'b0);
    do_reset();

    // T3: gapped bits ignored; a would-be hit with en=0 must not strobe
    overlap = 1'b1;
    bit_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bit_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_cnt("t3", 1, 1, 1'b0);
    do_reset();

    // T4: reset between "10" and "1" aborts the match; then a fresh 1,0,1 hits
    bit_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bit_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bit_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bit_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();

    // T5: five overlapping matches; 2-bit counter saturates on the third
    overlap = 1'b1;
    bit_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int m = 1; m <= 5; m++) begin
      bit_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      bit_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      if (m == 2) check_cnt("t5m2", 2, 2, 1'b0);
      else if (m == 3) check_cnt("t5m3", 3, 3, 1'b1);
      else if (m == 5) check_cnt("t5m5", 5, 3, 1'b1);
    end
    do_reset();
    check_cnt("t5rst", 0, 0, 1'b0);

    // T6: 1111 with six ones, overlapping then non-overlapping
    overlap = 1'b1;
    for (int i = 1; i <= 6; i++) bit_in(1'b0, 1'b1, 1'b1, 1'b0, (i >= 4));
    do_reset();
    overlap = 1'b0;
    for (int i = 1; i <= 6; i++) bit_in(1'b0, 1'b1, 1'b1, 1'b0, (i == 4));
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
